jzjpcc_mem_controller: RTL and testbench
========================================

JZJPCC_MEM_CONTROLLER -- requirements
Module: jzjpcc_mem_controller

Interface
REQ-001 Parameters: none.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Ports (name, direction, width, meaning):
  - clock  in  1  rising-edge clock.
  - reset  in  1  synchronous, active-high.
  - req_valid  in  1  execute stage presents a load/store.
  - req_write  in  1  1 = store, 0 = load.
  - req_funct3  in  3  RV32I funct3.
  - req_address  in  32  byte address (ALU result).
  - req_storeData  in  32  rs2 value.
  - stall  out  1  freeze pipeline.
  - load_valid  out  1  load result valid this cycle.
  - load_data  out  32  extended load result.
  - mem_address  out  30  word address to data memory.
  - mem_writeEnable  out  1  write strobe.
  - mem_byteMask  out  4  byte lanes written.
  - mem_writeData  out  32  lane-aligned write data.
  - mem_readData  in  32  synchronous read data, valid 1 cycle after mem_address.

Function
REQ-004 The FSM SHALL have the states IDLE, LOW, HIGH and DONE.
REQ-005 The FSM SHALL take IDLE->LOW on req_valid when funct3 is legal, and IDLE->DONE on req_valid when funct3 is illegal.
REQ-006 The FSM SHALL take LOW->HIGH when the access is split, otherwise LOW->DONE.
REQ-007 The FSM SHALL take HIGH->DONE, then DONE->IDLE unconditionally.
REQ-008 In IDLE with req_valid, the block SHALL register the address, write flag, funct3 and store data.
REQ-009 stall SHALL be 1 in IDLE when req_valid=1, 1 in LOW and HIGH, and 0 in DONE.
REQ-010 In DONE the pipeline advances, and req_valid SHALL be ignored in DONE.
REQ-011 Legal funct3 values and sizes:
  - 000 = B, 1 byte, sign-extended.
  - 001 = H, 2 bytes, sign-extended.
  - 010 = W, 4 bytes.
  - 100 = BU, 1 byte, zero-extended.
  - 101 = HU, 2 bytes, zero-extended.
  - 100 and 101 are legal for loads only.
  - Every other funct3 value, and BU/HU with write=1, is illegal.
REQ-012 With offset o = address[1:0] and size s bytes, the access SHALL be split iff o+s > 4.
REQ-013 word0 SHALL be address[31:2], and word1 SHALL be word0+1 modulo 2^30 (0x3FFFFFFF wraps to 0).
REQ-014 mem_address SHALL be word0 in LOW and word1 in HIGH.
REQ-015 The 8-bit mask SHALL be ((1<<s)-1)<<o; bits[3:0] are driven in LOW and bits[7:4] in HIGH.
REQ-016 The 64-bit store data SHALL be {32'b0, storeData}<<(8*o); bits[31:0] are driven in LOW and bits[63:32] in HIGH.
REQ-017 mem_writeEnable SHALL be 1 in LOW/HIGH for stores only, and never when the mask nibble is 0.
REQ-018 In every other state, mem_address, mem_byteMask, mem_writeData and mem_writeEnable SHALL be 0.
REQ-019 Load, unsplit: the block SHALL form the result in DONE from mem_readData (word0 data).
REQ-020 Load, split: in HIGH the block SHALL register mem_readData as w0; in DONE it SHALL use {mem_readData, w0}.
REQ-021 Load result: the 64-bit word SHALL be shifted right by 8*o, the low s bytes taken, then sign- or zero-extended per funct3.
REQ-022 load_valid SHALL be 1 only in DONE of a legal load, and load_data SHALL be 0 whenever load_valid=0.
REQ-023 An illegal request SHALL perform no memory access, reach DONE at T+1 with load_valid=0, and drive stall=1 at T only.
REQ-024 Latency (request first seen at cycle T):
  - Unsplit: stall=1 at T and T+1; DONE at T+2.
  - Split: stall=1 at T to T+2; DONE at T+3.
REQ-025 Back-to-back requests SHALL each start from IDLE, one dead-free IDLE acceptance per request.

Reset
REQ-026 A clock edge with reset=1 SHALL force IDLE from any state, including mid-split, and SHALL clear w0 and the registered request.
REQ-027 While reset=1, stall, load_valid and mem_writeEnable SHALL be 0, and req_valid SHALL NOT be accepted.
REQ-028 After reset, all outputs SHALL read 0, and no partial HIGH write SHALL be issued for a store aborted in LOW.

Verification
REQ-029 SW addr 0x100, data 0xDEADBEEF:
  - LOW: mem_address=0x40, mask=1111, data=0xDEADBEEF, we=1.
  - stall high 2 cycles.
REQ-030 SH addr 0x103, data 0x0000ABCD:
  - LOW: addr 0x40, mask=1000, data=0xCD000000.
  - HIGH: addr 0x41, mask=0001, data=0x000000AB.
  - stall high 3 cycles.
REQ-031 LW addr 0x102, memory word 0x40=0x44332211, word 0x41=0x88776655:
  - load_data=0x66554433 in DONE at T+3.
REQ-032 LB addr 0x101 with word 0x80FF7F00: load_data=0x0000007F. LB addr 0x102: load_data=0xFFFFFFFF. LBU addr 0x102: load_data=0x000000FF.
REQ-033 Wrap and abort:
  - SW at 0xFFFFFFFD: HIGH mem_address=0x00000000.
  - reset asserted in LOW of a split SH: IDLE next cycle, no HIGH write, all outputs 0.
REQ-034 funct3=011 store: no write, load_valid=0, stall high exactly 1 cycle.

Source files
------------

// File: rtl/jzjpcc_mem_controller.sv
// Data-memory controller for the execute stage: aligns loads and stores,
// splits misaligned accesses into two word cycles and stalls the pipeline.
module jzjpcc_mem_controller (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_address,
  input  logic [31:0] req_storeData,
  output logic        stall,
  output logic        load_valid,
  output logic [31:0] load_data,
  output logic [29:0] mem_address,
  output logic        mem_writeEnable,
  output logic [3:0]  mem_byteMask,
  output logic [31:0] mem_writeData,
  input  logic [31:0] mem_readData
);

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic [31:0] addr_q;
  logic        write_q;
  logic [2:0]  funct3_q;
  logic [31:0] data_q;
  logic [31:0] w0_q;

  function automatic logic legal_f(
    input logic [2:0] f3,
    input logic       wr
  );
    logic ok;
    case (f3)
      3'b000,
      3'b001,
      3'b010:  ok = 1'b1;
      3'b100,
      3'b101:  ok = ~wr;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  logic        legal_q;
  logic [1:0]  off;
  logic [2:0]  size;
  logic [3:0]  base;
  logic        split;
  logic [7:0]  mask8;
  logic [63:0] wdata64;
  logic [29:0] word0;
  logic [29:0] word1;
  logic [63:0] rdata64;
  logic [31:0] sh32;
  logic        sgn;
  logic [31:0] ext;

  always_comb begin
    legal_q = legal_f(funct3_q, write_q);
    off     = addr_q[1:0];
    case (funct3_q[1:0])
      2'b00:   begin size = 3'd1; base = 4'b0001; end
      2'b01:   begin size = 3'd2; base = 4'b0011; end
      default: begin size = 3'd4; base = 4'b1111; end
    endcase
    split   = ({1'b0, off} + size) > 3'd4;
    mask8   = {4'b0000, base} << off;
    wdata64 = {32'b0, data_q} << {off, 3'b000};
    word0   = addr_q[31:2];
    word1   = word0 + 30'd1;
    // A split load combines the registered low word with the current read.
    rdata64 = split ? {mem_readData, w0_q}
                    : {32'b0, mem_readData};
    sh32    = rdata64[{1'b0, off, 3'b000} +: 32];
    sgn     = ~funct3_q[2];
    case (size)
      3'd1:    ext = {{24{sgn & sh32[7]}}, sh32[7:0]};
      3'd2:    ext = {{16{sgn & sh32[15]}}, sh32[15:0]};
      default: ext = sh32;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    stall           = 1'b0;
    load_valid      = 1'b0;
    load_data       = 32'b0;
    mem_address     = 30'b0;
    mem_writeEnable = 1'b0;
    mem_byteMask    = 4'b0;
    mem_writeData   = 32'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          stall   = 1'b1;
          state_d = legal_f(req_funct3, req_write) ? LOW : DONE;
        end
      end
      LOW: begin
        stall           = 1'b1;
        mem_address     = word0;
        mem_byteMask    = mask8[3:0];
        mem_writeData   = wdata64[31:0];
        mem_writeEnable = write_q & (|mask8[3:0]);
        state_d         = split ? HIGH : DONE;
      end
      HIGH: begin
        stall           = 1'b1;
        mem_address     = word1;
        mem_byteMask    = mask8[7:4];
        mem_writeData   = wdata64[63:32];
        mem_writeEnable = write_q & (|mask8[7:4]);
        state_d         = DONE;
      end
      DONE: begin
        state_d = IDLE;
        if (legal_q && !write_q) begin
          load_valid = 1'b1;
          load_data  = ext;
        end
      end
      default: state_d = IDLE;
    endcase
    // Reset quiets every output so an aborted access never reaches memory.
    if (reset) begin
      state_d         = IDLE;
      stall           = 1'b0;
      load_valid      = 1'b0;
      load_data       = 32'b0;
      mem_address     = 30'b0;
      mem_writeEnable = 1'b0;
      mem_byteMask    = 4'b0;
      mem_writeData   = 32'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= 32'b0;
      write_q  <= 1'b0;
      funct3_q <= 3'b0;
      data_q   <= 32'b0;
      w0_q     <= 32'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req_valid) begin
        addr_q   <= req_address;
        write_q  <= req_write;
        funct3_q <= req_funct3;
        data_q   <= req_storeData;
      end
      if (state_q == HIGH) begin
        w0_q <= mem_readData;
      end
    end
  end

endmodule

// File: tb/tb_jzjpcc_mem_controller.sv
// Directed bench for jzjpcc_mem_controller with a small word memory model.
module tb_jzjpcc_mem_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_address;
  logic [31:0] req_storeData;
  logic        stall;
  logic        load_valid;
  logic [31:0] load_data;
  logic [29:0] mem_address;
  logic        mem_writeEnable;
  logic [3:0]  mem_byteMask;
  logic [31:0] mem_writeData;
  logic [31:0] mem_readData;

  logic [31:0] mem [0:255];
  logic        poke_en = 1'b0;
  logic [7:0]  poke_addr = 8'h0;
  logic [31:0] poke_data = 32'h0;

  int errors = 0;
  int checks = 0;

  jzjpcc_mem_controller dut (
    .clock          (clock),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_write      (req_write),
    .req_funct3     (req_funct3),
    .req_address    (req_address),
    .req_storeData  (req_storeData),
    .stall          (stall),
    .load_valid     (load_valid),
    .load_data      (load_data),
    .mem_address    (mem_address),
    .mem_writeEnable(mem_writeEnable),
    .mem_byteMask   (mem_byteMask),
    .mem_writeData  (mem_writeData),
    .mem_readData   (mem_readData)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (poke_en) begin
      mem[poke_addr] <= poke_data;
    end else if (mem_writeEnable) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_byteMask[i]) begin
          mem[mem_address[7:0]][8*i +: 8] <= mem_writeData[8*i +: 8];
        end
      end
    end
    mem_readData <= mem[mem_address[7:0]];
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [31:0] d);
    poke_en   = 1'b1;
    poke_addr = a;
    poke_data = d;
    tick();
    poke_en   = 1'b0;
  endtask

  task automatic req(input logic w, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] d);
    req_valid     = 1'b1;
    req_write     = w;
    req_funct3    = f3;
    req_address   = a;
    req_storeData = d;
    #1;
  endtask

  task automatic zeros(input string tag);
    chk({tag, "_stall"}, {31'b0, stall}, 32'h0);
    chk({tag, "_lv"}, {31'b0, load_valid}, 32'h0);
    chk({tag, "_ld"}, load_data, 32'h0);
    chk({tag, "_addr"}, {2'b0, mem_address}, 32'h0);
    chk({tag, "_we"}, {31'b0, mem_writeEnable}, 32'h0);
    chk({tag, "_mask"}, {28'b0, mem_byteMask}, 32'h0);
    chk({tag, "_wd"}, mem_writeData, 32'h0);
  endtask

  initial begin
    reset         = 1'b1;
    req_valid     = 1'b0;
    req_write     = 1'b0;
    req_funct3    = 3'b0;
    req_address   = 32'h0;
    req_storeData = 32'h0;
    tick();
    tick();
    // request presented while reset is held must not stall
    req(1'b1, 3'b010, 32'h100, 32'h1);
    chk("rst_stall", {31'b0, stall}, 32'h0);
    chk("rst_we", {31'b0, mem_writeEnable}, 32'h0);
    tick();
    req_valid = 1'b0;
    reset     = 1'b0;
    #1;
    zeros("post_rst");

    // SW 0x100
    tick();
    req(1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
    chk("sw_t0_stall", {31'b0, stall}, 32'h1);
    tick();
    req_valid = 1'b0;
    chk("sw_low_addr", {2'b0, mem_address}, 32'h40);
    chk("sw_low_mask", {28'b0, mem_byteMask}, 32'hF);
    chk("sw_low_wd", mem_writeData, 32'hDEADBEEF);
    chk("sw_low_we", {31'b0, mem_writeEnable}, 32'h1);
    chk("sw_low_stall", {31'b0, stall}, 32'h1);
    tick();
    chk("sw_done_stall", {31'b0, stall}, 32'h0);
    chk("sw_done_we", {31'b0, mem_writeEnable}, 32'h0);
    chk("sw_done_lv", {31'b0, load_valid}, 32'h0);
    chk("sw_mem40", mem[8'h40], 32'hDEADBEEF);

    // SH 0x103 split
    tick();
    req(1'b1, 3'b001, 32'h103, 32'h0000ABCD);
    chk("sh_t0_stall", {31'b0, stall}, 32'h1);
    tick();
    req_valid = 1'b0;
    chk("sh_low_addr", {2'b0, mem_address}, 32'h40);
    chk("sh_low_mask", {28'b0, mem_byteMask}, 32'h8);
    chk("sh_low_wd", mem_writeData, 32'hCD000000);
    chk("sh_low_stall", {31'b0, stall}, 32'h1);
    tick();
    chk("sh_high_addr", {2'b0, mem_address}, 32'h41);
    chk("sh_high_mask", {28'b0, mem_byteMask}, 32'h1);
    chk("sh_high_wd", mem_writeData, 32'h000000AB);
    chk("sh_high_we", {31'b0, mem_writeEnable}, 32'h1);
    chk("sh_high_stall", {31'b0, stall}, 32'h1);
    tick();
    chk("sh_done_stall", {31'b0, stall}, 32'h0);
    chk("sh_mem40", mem[8'h40], 32'hCDADBEEF);
    tick();

    // LW 0x102 split across 0x40/0x41
    poke(8'h40, 32'h44332211);
    poke(8'h41, 32'h88776655);
    req(1'b0, 3'b010, 32'h102, 32'h0);
    chk("lw_t0_stall", {31'b0, stall}, 32'h1);
    tick();
    req_valid = 1'b0;
    chk("lw_low_addr", {2'b0, mem_address}, 32'h40);
    chk("lw_low_we", {31'b0, mem_writeEnable}, 32'h0);
    tick();
    chk("lw_high_addr", {2'b0, mem_address}, 32'h41);
    chk("lw_high_lv", {31'b0, load_valid}, 32'h0);
    tick();
    chk("lw_done_lv", {31'b0, load_valid}, 32'h1);
    chk("lw_done_ld", load_data, 32'h66554433);
    chk("lw_done_stall", {31'b0, stall}, 32'h0);
    tick();
    chk("lw_idle_ld", load_data, 32'h0);

    // byte loads from 0x80FF7F00
    poke(8'h40, 32'h80FF7F00);
    req(1'b0, 3'b000, 32'h101, 32'h0);
    tick();
    req_valid = 1'b0;
    tick();
    chk("lb101_lv", {31'b0, load_valid}, 32'h1);
    chk("lb101_ld", load_data, 32'h0000007F);
    tick();
    req(1'b0, 3'b000, 32'h102, 32'h0);
    tick();
    req_valid = 1'b0;
    tick();
    chk("lb102_ld", load_data, 32'hFFFFFFFF);
    tick();
    req(1'b0, 3'b100, 32'h102, 32'h0);
    tick();
    req_valid = 1'b0;
    tick();
    chk("lbu102_ld", load_data, 32'h000000FF);
    tick();
    req(1'b0, 3'b001, 32'h102, 32'h0);
    tick();
    req_valid = 1'b0;
    tick();
    chk("lh102_ld", load_data, 32'hFFFF80FF);
    tick();

    // SW at 0xFFFFFFFD wraps the word address
    req(1'b1, 3'b010, 32'hFFFFFFFD, 32'h11223344);
    tick();
    req_valid = 1'b0;
    chk("wrap_low_addr", {2'b0, mem_address}, 32'h3FFFFFFF);
    chk("wrap_low_mask", {28'b0, mem_byteMask}, 32'hE);
    chk("wrap_low_wd", mem_writeData, 32'h22334400);
    tick();
    chk("wrap_high_addr", {2'b0, mem_address}, 32'h0);
    chk("wrap_high_mask", {28'b0, mem_byteMask}, 32'h1);
    chk("wrap_high_wd", mem_writeData, 32'h00000011);
    chk("wrap_high_stall", {31'b0, stall}, 32'h1);
    tick();
    tick();

    // reset during LOW of a split SH aborts it
    poke(8'h40, 32'h11111111);
    req(1'b1, 3'b001, 32'h103, 32'h00001234);
    tick();
    req_valid = 1'b0;
    reset     = 1'b1;
    #1;
    chk("abort_rst_we", {31'b0, mem_writeEnable}, 32'h0);
    chk("abort_rst_stall", {31'b0, stall}, 32'h0);
    tick();
    reset = 1'b0;
    #1;
    zeros("abort_idle");
    tick();
    zeros("abort_next");
    chk("abort_mem40", mem[8'h40], 32'h11111111);
    chk("abort_mem41", mem[8'h41], 32'h88776655);

    // illegal funct3=011 store, request held high through DONE
    req(1'b1, 3'b011, 32'h40, 32'hFFFFFFFF);
    chk("ill_t0_stall", {31'b0, stall}, 32'h1);
    tick();
    chk("ill_done_stall", {31'b0, stall}, 32'h0);
    chk("ill_done_lv", {31'b0, load_valid}, 32'h0);
    chk("ill_done_we", {31'b0, mem_writeEnable}, 32'h0);
    chk("ill_done_addr", {2'b0, mem_address}, 32'h0);
    tick();
    chk("ill_again_stall", {31'b0, stall}, 32'h1);
    tick();
    req_valid = 1'b0;
    chk("ill_again_done", {31'b0, stall}, 32'h0);
    tick();
    chk("ill_idle_stall", {31'b0, stall}, 32'h0);
    chk("ill_mem10", mem[8'h10] === 32'hFFFFFFFF ? 32'h1 : 32'h0, 32'h0);

    // SBU-style store (funct3=100, write) is illegal
    req(1'b1, 3'b100, 32'h100, 32'h0);
    tick();
    req_valid = 1'b0;
    chk("sbu_done_stall", {31'b0, stall}, 32'h0);
    chk("sbu_done_we", {31'b0, mem_writeEnable}, 32'h0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
